imm_gen_pipe: RTL and testbench

- Pipelined, parametrised immediate generator placed between fetch and the decode/register-read stage.
- Accepts one 32-bit RV instruction per cycle over a valid/ready handshake.
- Classifies the instruction format and produces the XLEN-wide immediate one cycle later, with a 2-entry skid buffer for full throughput under backpressure.
- Adds JAL/JALR/SYSTEM/FENCE/OP decoding, shift-amount masking, illegal-opcode flagging and pipeline flush.

---
 rtl/imm_gen_pipe.sv | 134 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV immediate generator with format decode and a 2-entry skid buffer
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } ent_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  localparam logic [2:0] FMT_I = 3'd0, FMT_S = 3'd1, FMT_B = 3'd2, FMT_U = 3'd3,
                         FMT_J = 3'd4, FMT_R = 3'd5, FMT_X = 3'd6;
  state_t state_q, state_d;
  ent_t head_q, head_d, tail_q, tail_d, dec;
  logic push, pop;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [5:0] shamt;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  assign in_ready    = state_q != FULL;
  assign out_valid   = state_q != EMPTY;
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_imm     = head_q.imm;
  assign out_fmt     = head_q.fmt;
  assign out_illegal = head_q.ill;
  assign out_tag     = head_q.tag;
  assign opc         = in_inst[6:0];
  assign f3          = in_inst[14:12];
  // shift amount is 5 bits on RV32 and 6 bits on RV64; funct7 never leaks in
  assign shamt       = {(XLEN == 64) ? in_inst[25] : 1'b0, in_inst[24:20]};
  // candidate immediates for every format, all sign-extended from inst[31]
  always_comb begin
    imm_i  = XLEN'($signed(in_inst[31:20]));
    imm_s  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    imm_b  = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    imm_u  = XLEN'($signed({in_inst[31:12], 12'b0}));
    imm_j  = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
    imm_sh = XLEN'(shamt);
  end
  // classify the incoming word and pick its immediate before it is buffered
  always_comb begin
    dec     = '0;
    dec.tag = in_tag;
    case (opc)
      7'b0010011: begin
        dec.fmt = FMT_I;
        dec.imm = (f3 == 3'b001 || f3 == 3'b101) ? imm_sh : imm_i;
      end
      7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        dec.fmt = FMT_I;
        dec.imm = imm_i;
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        dec.imm = imm_s;
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        dec.imm = imm_b;
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        dec.imm = imm_u;
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        dec.imm = imm_j;
      end
      7'b0110011: dec.fmt = FMT_R;
      default: begin
        dec.fmt = FMT_X;
        dec.ill = 1'b1;
      end
    endcase
  end
  // occupancy and FIFO movement; head is always the entry on out_*
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          head_d  = dec;
          state_d = ONE;
        end
        ONE: if (push && pop) begin
          head_d = dec;
        end else if (push) begin
          tail_d  = dec;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
        FULL: if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  // state and entry registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed vector table plus backpressure, flush and reset sequences
module tb_imm_gen_pipe;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_inst = '0;
  logic [7:0] in_tag = '0;
  logic in_ready, out_valid, out_illegal, in_ready64, out_valid64, out_illegal64;
  logic [31:0] out_imm;
  logic [63:0] out_imm64;
  logic [2:0] out_fmt, out_fmt64;
  logic [7:0] out_tag, out_tag64;
  int total = 0, bad = 0;
  typedef struct {
    logic [31:0] inst;
    logic [31:0] e32;
    logic [63:0] e64;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;
  vec_t v[17];
  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag));
  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask
  task automatic drive(input logic vld, input logic [31:0] inst, input logic [7:0] tag);
    @(negedge clk);
    in_valid = vld;
    in_inst  = inst;
    in_tag   = tag;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    v[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0};
    v[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0};
    v[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0};
    v[3]  = '{32'hFFDFF0EF, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd4, 1'b0};
    v[4]  = '{32'h123450B7, 32'h12345000, 64'h0000000012345000, 3'd3, 1'b0};
    v[5]  = '{32'h4030D093, 32'h00000003, 64'h0000000000000003, 3'd0, 1'b0};
    v[6]  = '{32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd3, 1'b0};
    v[7]  = '{32'h00000000, 32'h00000000, 64'h0000000000000000, 3'd6, 1'b1};
    v[8]  = '{32'h0000007F, 32'h00000000, 64'h0000000000000000, 3'd6, 1'b1};
    v[9]  = '{32'h002081B3, 32'h00000000, 64'h0000000000000000, 3'd5, 1'b0};
    v[10] = '{32'h02009093, 32'h00000000, 64'h0000000000000020, 3'd0, 1'b0};
    v[11] = '{32'h7FF08067, 32'h000007FF, 64'h00000000000007FF, 3'd0, 1'b0};
    v[12] = '{32'h00112423, 32'h00000008, 64'h0000000000000008, 3'd1, 1'b0};
    v[13] = '{32'hFFFFF097, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 3'd3, 1'b0};
    v[14] = '{32'h00000012, 32'h00000000, 64'h0000000000000000, 3'd6, 1'b1};
    v[15] = '{32'h0FF0000F, 32'h000000FF, 64'h00000000000000FF, 3'd0, 1'b0};
    v[16] = '{32'h00000073, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b0};
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_imm", out_imm64, 64'd0);
    chk("rst_fmt", 64'(out_fmt), 64'd0);
    chk("rst_ill", 64'(out_illegal), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, v[i].inst, 8'(i + 16));
      step();
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_imm32", i), 64'(out_imm), 64'(v[i].e32));
      chk($sformatf("v%0d_imm64", i), out_imm64, v[i].e64);
      chk($sformatf("v%0d_fmt", i), 64'(out_fmt), 64'(v[i].fmt));
      chk($sformatf("v%0d_ill", i), 64'(out_illegal), 64'(v[i].ill));
      chk($sformatf("v%0d_tag", i), 64'(out_tag), 64'(i + 16));
    end
    drive(1'b0, 32'h0, 8'h0);
    step();
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 8'd1);
    step();
    chk("bp1_valid", 64'(out_valid), 64'd1);
    chk("bp1_tag", 64'(out_tag), 64'd1);
    chk("bp1_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h00200093, 8'd2);
    step();
    chk("bp2_tag", 64'(out_tag), 64'd1);
    chk("bp2_imm", 64'(out_imm), 64'd1);
    chk("bp2_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h00300093, 8'd3);
    step();
    chk("bp3_tag", 64'(out_tag), 64'd1);
    chk("bp3_imm", 64'(out_imm), 64'd1);
    chk("bp3_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    step();
    chk("rel1_tag", 64'(out_tag), 64'd2);
    chk("rel1_imm", 64'(out_imm), 64'd2);
    chk("rel1_ready", 64'(in_ready), 64'd1);
    step();
    chk("rel2_valid", 64'(out_valid), 64'd1);
    chk("rel2_tag", 64'(out_tag), 64'd3);
    chk("rel2_imm", 64'(out_imm), 64'd3);
    drive(1'b0, 32'h0, 8'h0);
    step();
    chk("rel3_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    drive(1'b1, 32'h00400093, 8'd4);
    step();
    drive(1'b1, 32'h00500093, 8'd5);
    step();
    chk("fl_full", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h00600093, 8'd6);
    flush = 1'b1;
    step();
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h00700093, 8'd7);
    out_ready = 1'b1;
    step();
    chk("fl1_valid", 64'(out_valid), 64'd0);
    drive(1'b0, 32'h0, 8'h0);
    flush = 1'b0;
    step();
    chk("fl2_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 32'h00800093, 8'd8);
    step();
    chk("post_fl_tag", 64'(out_tag), 64'd8);
    chk("post_fl_imm", 64'(out_imm), 64'd8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    chk("arst_imm", 64'(out_imm), 64'd0);
    chk("arst_tag", 64'(out_tag), 64'd0);
    chk("arst_imm64", out_imm64, 64'd0);
    drive(1'b0, 32'h0, 8'h0);
    rst_n = 1'b1;
    step();
    chk("end_valid", 64'(out_valid), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
